// File: rtl/seg_addsub_pipe_pkg.sv
// Shared types and defaults for the segmented add/sub pipeline.
// Provides the BN254 field-element word type, default geometry, and the
// segment-sum layout (carry bit above a SEGW-bit value).
package seg_addsub_pipe_pkg;

  localparam int unsigned FP_W     = 272;
  localparam int unsigned DEF_NSEG = 4;   // default segment count == default latency
  localparam int unsigned DEF_TAGW = 8;
  localparam int unsigned DEF_SEGW = FP_W / DEF_NSEG;

  typedef logic [FP_W-1:0] uint_fp_t;

  // Segment sum at the default geometry; modules with other SEGW declare the
  // same layout locally at their own width.
  typedef struct packed {
    logic                carry;
    logic [DEF_SEGW-1:0] val;
  } seg_sum_t;

endpackage

// File: rtl/seg_carry_stage.sv
// One carry-resolve pipeline stage.
// Ports: clk, rst_n, adv (global advance); vld_i/sub_i/tag_i/seg_i from the
// previous stage; vld_o/sub_o/tag_o/seg_o registered towards the next stage.
// Folds the carry of segment IDX-1 into segment IDX and clears that carry.
module seg_carry_stage
  import seg_addsub_pipe_pkg::*;
#(
  parameter int unsigned SEGW = DEF_SEGW,
  parameter int unsigned NSEG = DEF_NSEG,
  parameter int unsigned TAGW = DEF_TAGW,
  parameter int unsigned IDX  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     adv,
  input  logic                     vld_i,
  input  logic                     sub_i,
  input  logic [TAGW-1:0]          tag_i,
  input  logic [NSEG-1:0][SEGW:0]  seg_i,
  output logic                     vld_o,
  output logic                     sub_o,
  output logic [TAGW-1:0]          tag_o,
  output logic [NSEG-1:0][SEGW:0]  seg_o
);

  typedef struct packed {
    logic            carry;
    logic [SEGW-1:0] val;
  } seg_t;

  seg_t [NSEG-1:0] seg_in;
  seg_t [NSEG-1:0] seg_d, seg_q;
  logic            vld_d, vld_q;
  logic            sub_d, sub_q;
  logic [TAGW-1:0] tag_d, tag_q;

  assign seg_in = seg_i;

  // Shift forward on adv; the incoming carry cannot overflow SEGW+1 bits.
  always_comb begin
    vld_d = vld_q;
    sub_d = sub_q;
    tag_d = tag_q;
    seg_d = seg_q;
    if (adv) begin
      vld_d              = vld_i;
      sub_d              = sub_i;
      tag_d              = tag_i;
      seg_d              = seg_in;
      seg_d[IDX]         = seg_t'(seg_in[IDX] + (SEGW+1)'(seg_in[IDX-1].carry));
      seg_d[IDX-1].carry = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      sub_q <= 1'b0;
      tag_q <= '0;
      seg_q <= '0;
    end else begin
      vld_q <= vld_d;
      sub_q <= sub_d;
      tag_q <= tag_d;
      seg_q <= seg_d;
    end
  end

  assign vld_o = vld_q;
  assign sub_o = sub_q;
  assign tag_o = tag_q;
  assign seg_o = seg_q;

endmodule

// File: rtl/seg_addsub_pipe.sv
// Pipelined wide add/sub with segment-serial carry resolution.
// Ports: clk, rst_n; in_valid/in_ready/in_sub/in_x/in_y/in_tag input
// handshake; out_valid/out_ready/out_z/out_flag/out_tag result handshake.
// Latency NSEG cycles; one global advance stalls the whole pipe.
module seg_addsub_pipe
  import seg_addsub_pipe_pkg::*;
#(
  parameter int unsigned W    = $bits(uint_fp_t),
  parameter int unsigned NSEG = DEF_NSEG,
  parameter int unsigned TAGW = DEF_TAGW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_sub,
  input  logic [W-1:0]    in_x,
  input  logic [W-1:0]    in_y,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_z,
  output logic            out_flag,
  output logic [TAGW-1:0] out_tag
);

  localparam int unsigned SEGW = W / ((NSEG == 0) ? 1 : NSEG);

  if (NSEG < 1 || TAGW < 1 || (W % ((NSEG == 0) ? 1 : NSEG)) != 0) begin : g_bad_cfg
    $error("seg_addsub_pipe: W must be a multiple of NSEG, NSEG >= 1, TAGW >= 1");
  end

  logic adv;

  // Stage 0: independent per-segment sums, carry-in 1 on segment 0 for sub.
  logic [NSEG-1:0][SEGW:0] s0_d, s0_q;
  logic                    v0_d, v0_q;
  logic                    sub0_d, sub0_q;
  logic [TAGW-1:0]         tag0_d, tag0_q;
  logic [W-1:0]            yp;

  always_comb begin
    s0_d   = s0_q;
    v0_d   = v0_q;
    sub0_d = sub0_q;
    tag0_d = tag0_q;
    yp     = in_sub ? ~in_y : in_y;
    if (adv) begin
      v0_d   = in_valid;
      sub0_d = in_sub;
      tag0_d = in_tag;
      for (int unsigned i = 0; i < NSEG; i++) begin
        s0_d[i] = (SEGW+1)'(in_x[i*SEGW +: SEGW]) + (SEGW+1)'(yp[i*SEGW +: SEGW])
                + (SEGW+1)'(in_sub && (i == 0));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q   <= '0;
      v0_q   <= 1'b0;
      sub0_q <= 1'b0;
      tag0_q <= '0;
    end else begin
      s0_q   <= s0_d;
      v0_q   <= v0_d;
      sub0_q <= sub0_d;
      tag0_q <= tag0_d;
    end
  end

  // Carry-resolve chain: stage k folds segment k-1's carry into segment k.
  logic [NSEG-1:0][SEGW:0] seg_w [NSEG];
  logic                    vld_w [NSEG];
  logic                    sub_w [NSEG];
  logic [TAGW-1:0]         tag_w [NSEG];

  assign seg_w[0] = s0_q;
  assign vld_w[0] = v0_q;
  assign sub_w[0] = sub0_q;
  assign tag_w[0] = tag0_q;

  for (genvar k = 1; k < NSEG; k++) begin : g_stage
    seg_carry_stage #(
      .SEGW (SEGW),
      .NSEG (NSEG),
      .TAGW (TAGW),
      .IDX  (k)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .adv   (adv),
      .vld_i (vld_w[k-1]),
      .sub_i (sub_w[k-1]),
      .tag_i (tag_w[k-1]),
      .seg_i (seg_w[k-1]),
      .vld_o (vld_w[k]),
      .sub_o (sub_w[k]),
      .tag_o (tag_w[k]),
      .seg_o (seg_w[k])
    );
  end

  // Output view of the last stage; lower carries are already cleared.
  logic [NSEG-1:0][SEGW:0] last_seg;
  logic [NSEG-1:0]         carry_unused;

  assign last_seg = seg_w[NSEG-1];

  for (genvar i = 0; i < NSEG; i++) begin : g_out
    assign out_z[i*SEGW +: SEGW] = last_seg[i][SEGW-1:0];
    assign carry_unused[i]       = last_seg[i][SEGW];
  end

  assign out_valid = vld_w[NSEG-1];
  assign out_tag   = tag_w[NSEG-1];
  // Sub produces carry = NOT borrow, so invert it to report X < Y.
  assign out_flag  = sub_w[NSEG-1] ^ last_seg[NSEG-1][SEGW];

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

endmodule
